// File: rtl/axi4_sram_slave.sv
`default_nettype none
// ============================================================================
// axi4_sram_slave : AXI4 responder over a word-addressed on-chip SRAM array.
// Rev 1.0
// ============================================================================
module axi4_sram_slave #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned RD_DELAY    = 2,
   parameter int unsigned WR_DELAY    = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awid,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   output logic [3:0]  bid,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic [3:0]  rid
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

   function automatic logic in_range(input logic [31:0] a);
      return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE_ADDR;
      return IDX_W'(off >> 2);
   endfunction

   // FIXED holds the address; INCR, WRAP and reserved all step by the beat size.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                             input logic [2:0] size);
      return (burst == 2'b00) ? a : a + (32'd1 << size);
   endfunction

   logic [31:0] mem_q [DEPTH_WORDS];

   // ------------------------------------------------------------------ write
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_e;

   wstate_e     wstate_q;
   logic        awready_q, wready_q, bvalid_q;
   logic [1:0]  bresp_q;
   logic [3:0]  bid_q, wid_q;
   logic [31:0] waddr_q;
   logic [7:0]  wlen_q, wbeat_q;
   logic [2:0]  wsize_q;
   logic [1:0]  wburst_q;
   logic [15:0] wdelay_q;
   logic        decerr_q, slverr_q;
   logic        w_hs, wr_en_d;

   assign w_hs    = (wstate_q == W_DATA) && wvalid && wready_q;
   assign wr_en_d = w_hs && in_range(waddr_q);

   always_ff @(posedge clock) begin
      if (wr_en_d) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem_q[word_idx(waddr_q)][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         bid_q     <= '0;
         wid_q     <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wbeat_q   <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
         wdelay_q  <= '0;
         decerr_q  <= 1'b0;
         slverr_q  <= 1'b0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (awvalid && awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  waddr_q   <= awaddr;
                  wid_q     <= awid;
                  wlen_q    <= awlen;
                  wsize_q   <= awsize;
                  wburst_q  <= awburst;
                  wbeat_q   <= '0;
                  decerr_q  <= 1'b0;
                  slverr_q  <= awburst[1];
                  wstate_q  <= W_DATA;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  if (!in_range(waddr_q)) decerr_q <= 1'b1;
                  if (wlast != (wbeat_q == wlen_q)) slverr_q <= 1'b1;
                  waddr_q <= next_addr(waddr_q, wburst_q, wsize_q);
                  wbeat_q <= wbeat_q + 8'd1;
                  if (wbeat_q == wlen_q) begin
                     wready_q <= 1'b0;
                     wdelay_q <= '0;
                     wstate_q <= (WR_DELAY > 0) ? W_WAIT : W_RESP;
                  end
               end
            end
            W_WAIT: begin
               if (wdelay_q == 16'(WR_DELAY - 1)) wstate_q <= W_RESP;
               else wdelay_q <= wdelay_q + 16'd1;
            end
            W_RESP: begin
               if (!bvalid_q) begin
                  bvalid_q <= 1'b1;
                  bid_q    <= wid_q;
                  bresp_q  <= decerr_q ? 2'b11 : (slverr_q ? 2'b10 : 2'b00);
               end else if (bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wstate_q  <= W_IDLE;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bresp   = bresp_q;
   assign bid     = bid_q;

   // ------------------------------------------------------------------- read
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;

   rstate_e     rstate_q;
   logic        arready_q, rvalid_q, rlast_q;
   logic [31:0] rdata_q, raddr_q;
   logic [1:0]  rresp_q, rburst_q;
   logic [3:0]  rid_q, arid_q;
   logic [7:0]  rlen_q, rbeat_q;
   logic [2:0]  rsize_q;
   logic [15:0] rdelay_q;

   logic [31:0] rd_addr_d, rdata_d;
   logic [7:0]  rd_beat_d, rd_len_d;
   logic [1:0]  rd_burst_d, rresp_d;
   logic [3:0]  rd_id_d;
   logic        rd_hit, rlast_d;

   // Beat to be presented next: straight from AR when the delay is zero,
   // the latched first beat after a wait, or the following beat on a handshake.
   always_comb begin
      rd_addr_d  = raddr_q;
      rd_beat_d  = rbeat_q;
      rd_len_d   = rlen_q;
      rd_burst_d = rburst_q;
      rd_id_d    = arid_q;
      if (rstate_q == R_IDLE) begin
         rd_addr_d  = araddr;
         rd_beat_d  = '0;
         rd_len_d   = arlen;
         rd_burst_d = arburst;
         rd_id_d    = arid;
      end else if (rstate_q == R_DATA) begin
         rd_addr_d = next_addr(raddr_q, rburst_q, rsize_q);
         rd_beat_d = rbeat_q + 8'd1;
      end
   end

   assign rd_hit  = in_range(rd_addr_d);
   assign rdata_d = rd_hit ? mem_q[word_idx(rd_addr_d)] : 32'd0;
   assign rresp_d = !rd_hit ? 2'b11 : (rd_burst_d[1] ? 2'b10 : 2'b00);
   assign rlast_d = (rd_beat_d == rd_len_d);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rstate_q  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
         rid_q     <= '0;
         arid_q    <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rdelay_q  <= '0;
      end else begin
         case (rstate_q)
            R_IDLE: begin
               if (arvalid && arready_q) begin
                  arready_q <= 1'b0;
                  raddr_q   <= araddr;
                  arid_q    <= arid;
                  rlen_q    <= arlen;
                  rsize_q   <= arsize;
                  rburst_q  <= arburst;
                  rbeat_q   <= '0;
                  rdelay_q  <= '0;
                  if (RD_DELAY == 0) begin
                     rvalid_q <= 1'b1;
                     rdata_q  <= rdata_d;
                     rresp_q  <= rresp_d;
                     rlast_q  <= rlast_d;
                     rid_q    <= rd_id_d;
                     rstate_q <= R_DATA;
                  end else begin
                     rstate_q <= R_WAIT;
                  end
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_WAIT: begin
               if (rdelay_q == 16'(RD_DELAY - 1)) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= rdata_d;
                  rresp_q  <= rresp_d;
                  rlast_q  <= rlast_d;
                  rid_q    <= rd_id_d;
                  rstate_q <= R_DATA;
               end else begin
                  rdelay_q <= rdelay_q + 16'd1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     rstate_q  <= R_IDLE;
                  end else begin
                     raddr_q <= rd_addr_d;
                     rbeat_q <= rd_beat_d;
                     rdata_q <= rdata_d;
                     rresp_q <= rresp_d;
                     rlast_q <= rlast_d;
                     rid_q   <= rd_id_d;
                  end
               end
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rlast   = rlast_q;
   assign rid     = rid_q;

endmodule
`default_nettype wire
